// File: rtl/ic_mem_responder.sv
// Single-cycle memory responder: word-addressed SRAM behind a req/gnt command port
// and a 2-deep response FIFO drained by recv/ack.
module ic_mem_responder #(
  parameter int unsigned MEM_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h2000_0000,
  parameter bit          WRITABLE  = 1'b1
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        mem_req,
  input  logic        mem_wen,
  input  logic [3:0]  mem_strb,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] mem_addr,
  output logic        mem_gnt,
  output logic        mem_recv,
  input  logic        mem_ack,
  output logic        mem_error,
  output logic [31:0] mem_rdata,
  output logic [7:0]  err_count
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  logic [31:0] mem_array [MEM_WORDS];

  logic [1:0]  count;
  logic        wr_ptr;
  logic        rd_ptr;
  logic        fifo_err  [2];
  logic [31:0] fifo_data [2];

  logic [31:0]   word_off;
  logic [AW-1:0] word_idx;
  logic          misaligned;
  logic          out_of_range;
  logic          write_denied;
  logic          dec_err;
  logic          push;
  logic          pop;
  logic          valid_write;

  // Underflow of the subtract wraps to a huge offset, so it lands in out_of_range.
  assign word_off     = (mem_addr - BASE_ADDR) >> 2;
  assign word_idx     = word_off[AW-1:0];
  assign misaligned   = (mem_addr[1:0] != 2'b00);
  assign out_of_range = (word_off >= MEM_WORDS);
  assign write_denied = mem_wen && (WRITABLE == 1'b0);
  assign dec_err      = misaligned || out_of_range || write_denied;

  assign mem_gnt     = (count != 2'd2) && !g_reset;
  assign push        = mem_req && mem_gnt;
  assign pop         = mem_recv && mem_ack;
  assign valid_write = push && mem_wen && !dec_err;

  assign mem_recv  = (count != 2'd0);
  assign mem_error = mem_recv && fifo_err[rd_ptr];
  assign mem_rdata = mem_recv ? fifo_data[rd_ptr] : 32'h0;

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      count     <= 2'd0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      err_count <= 8'h00;
      for (int i = 0; i < 2; i++) begin
        fifo_err[i]  <= 1'b0;
        fifo_data[i] <= 32'h0;
      end
    end else begin
      if (push) begin
        fifo_err[wr_ptr]  <= dec_err;
        fifo_data[wr_ptr] <= (dec_err || mem_wen) ? 32'h0 : mem_array[word_idx];
        wr_ptr            <= ~wr_ptr;
        if (dec_err && (err_count != 8'hFF))
          err_count <= err_count + 8'd1;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Array is deliberately not reset; only accepted, decoded writes touch it.
  always_ff @(posedge g_clk) begin
    if (valid_write) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_strb[b])
          mem_array[word_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ic_mem_responder.sv
// Bench for ic_mem_responder: directed vector table, hand-written FIFO/reset
// sequences, a read-only instance, and a randomized run against a queue model.
module tb_ic_mem_responder;

  localparam logic [31:0] BASE = 32'h2000_0000;
  localparam int unsigned WORDS = 4096;

  logic        g_clk = 1'b0;
  logic        g_reset;
  logic        mem_req, mem_wen, mem_ack;
  logic [3:0]  mem_strb;
  logic [31:0] mem_wdata, mem_addr;
  logic        mem_gnt, mem_recv, mem_error;
  logic [31:0] mem_rdata;
  logic [7:0]  err_count;

  logic        rom_req, rom_wen, rom_ack;
  logic [3:0]  rom_strb;
  logic [31:0] rom_wdata, rom_addr;
  logic        rom_gnt, rom_recv, rom_error;
  logic [31:0] rom_rdata;
  logic [7:0]  rom_err_count;

  ic_mem_responder #(.MEM_WORDS(WORDS), .BASE_ADDR(BASE), .WRITABLE(1'b1)) dut (
    .g_clk(g_clk), .g_reset(g_reset), .mem_req(mem_req), .mem_wen(mem_wen),
    .mem_strb(mem_strb), .mem_wdata(mem_wdata), .mem_addr(mem_addr),
    .mem_gnt(mem_gnt), .mem_recv(mem_recv), .mem_ack(mem_ack),
    .mem_error(mem_error), .mem_rdata(mem_rdata), .err_count(err_count)
  );

  ic_mem_responder #(.MEM_WORDS(WORDS), .BASE_ADDR(BASE), .WRITABLE(1'b0)) u_rom (
    .g_clk(g_clk), .g_reset(g_reset), .mem_req(rom_req), .mem_wen(rom_wen),
    .mem_strb(rom_strb), .mem_wdata(rom_wdata), .mem_addr(rom_addr),
    .mem_gnt(rom_gnt), .mem_recv(rom_recv), .mem_ack(rom_ack),
    .mem_error(rom_error), .mem_rdata(rom_rdata), .err_count(rom_err_count)
  );

  always #5 g_clk = ~g_clk;

  typedef struct {
    logic        wen;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] addr;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] data;
  } resp_t;

  int errors = 0;
  int checks = 0;
  int err_model = 0;
  logic [31:0] model_mem [16];
  resp_t exp_q [$];
  vec_t vecs [15];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  // One isolated transaction with ack held high; FIFO must be empty on entry.
  task automatic applyStimulus(input vec_t v, input string tag);
    @(negedge g_clk);
    mem_req = 1'b1; mem_wen = v.wen; mem_strb = v.strb;
    mem_wdata = v.wdata; mem_addr = v.addr; mem_ack = 1'b1;
    checkOutput({tag, " gnt"}, 32'(mem_gnt), 32'd1);
    @(negedge g_clk);
    mem_req = 1'b0;
    if (v.exp_err && err_model < 255) err_model++;
    checkOutput({tag, " recv"}, 32'(mem_recv), 32'd1);
    checkOutput({tag, " error"}, 32'(mem_error), 32'(v.exp_err));
    checkOutput({tag, " rdata"}, mem_rdata, v.exp_rdata);
  endtask

  task automatic romTxn(input logic wen, input logic [31:0] wdata, input logic [31:0] addr,
                        output logic err, output logic [31:0] data);
    @(negedge g_clk);
    rom_req = 1'b1; rom_wen = wen; rom_strb = 4'hF; rom_wdata = wdata;
    rom_addr = addr; rom_ack = 1'b1;
    @(negedge g_clk);
    rom_req = 1'b0;
    checkOutput("rom recv", 32'(rom_recv), 32'd1);
    err  = rom_error;
    data = rom_rdata;
  endtask

  function automatic logic addr_is_error(input logic [31:0] a, input logic wen);
    return (a[1:0] != 2'b00) || (a < BASE) || (a >= BASE + 32'(WORDS * 4)) || (wen && 1'b0);
  endfunction

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic        e0, e1;
    logic [31:0] d0, d1;
    vec_t        v;

    g_reset = 1'b1;
    mem_req = 1'b0; mem_wen = 1'b0; mem_strb = 4'h0; mem_wdata = 32'h0;
    mem_addr = BASE; mem_ack = 1'b0;
    rom_req = 1'b0; rom_wen = 1'b0; rom_strb = 4'h0; rom_wdata = 32'h0;
    rom_addr = BASE; rom_ack = 1'b0;
    #1;
    checkOutput("reset gnt", 32'(mem_gnt), 32'd0);
    checkOutput("reset recv", 32'(mem_recv), 32'd0);
    checkOutput("reset error", 32'(mem_error), 32'd0);
    checkOutput("reset rdata", mem_rdata, 32'h0);
    checkOutput("reset err_count", 32'(err_count), 32'd0);
    repeat (3) @(posedge g_clk);
    @(negedge g_clk);
    g_reset = 1'b0;
    #1;
    checkOutput("post-reset gnt", 32'(mem_gnt), 32'd1);
    checkOutput("post-reset recv", 32'(mem_recv), 32'd0);

    vecs[0]  = '{1'b1, 4'hF,    32'hDEAD_BEEF, BASE + 32'h10,   1'b0, 32'h0};
    vecs[1]  = '{1'b0, 4'h0,    32'h0,         BASE + 32'h10,   1'b0, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 4'b0010, 32'h0000_5500, BASE + 32'h10,   1'b0, 32'h0};
    vecs[3]  = '{1'b0, 4'h0,    32'h0,         BASE + 32'h10,   1'b0, 32'hDEAD_55EF};
    vecs[4]  = '{1'b1, 4'b0000, 32'hFFFF_FFFF, BASE + 32'h10,   1'b0, 32'h0};
    vecs[5]  = '{1'b0, 4'h0,    32'h0,         BASE + 32'h10,   1'b0, 32'hDEAD_55EF};
    vecs[6]  = '{1'b1, 4'b1001, 32'h1234_5678, BASE + 32'h10,   1'b0, 32'h0};
    vecs[7]  = '{1'b0, 4'h0,    32'h0,         BASE + 32'h10,   1'b0, 32'h12AD_5578};
    vecs[8]  = '{1'b1, 4'hF,    32'hCAFE_F00D, 32'h2000_3FFC,   1'b0, 32'h0};
    vecs[9]  = '{1'b0, 4'h0,    32'h0,         32'h2000_3FFC,   1'b0, 32'hCAFE_F00D};
    vecs[10] = '{1'b0, 4'h0,    32'h0,         32'h1FFF_FFFC,   1'b1, 32'h0};
    vecs[11] = '{1'b0, 4'h0,    32'h0,         32'h2000_4000,   1'b1, 32'h0};
    vecs[12] = '{1'b0, 4'h0,    32'h0,         32'h2000_0002,   1'b1, 32'h0};
    vecs[13] = '{1'b1, 4'hF,    32'hFFFF_FFFF, 32'h2000_0012,   1'b1, 32'h0};
    vecs[14] = '{1'b0, 4'h0,    32'h0,         BASE + 32'h10,   1'b0, 32'h12AD_5578};

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
      checkOutput($sformatf("vec%0d err_count", i), 32'(err_count), 32'(err_model));
    end

    // Read-only instance: writes error out and leave the array untouched.
    romTxn(1'b0, 32'h0, BASE, e0, d0);
    checkOutput("rom read error", 32'(e0), 32'd0);
    romTxn(1'b1, 32'hA5A5_A5A5, BASE, e1, d1);
    checkOutput("rom write error", 32'(e1), 32'd1);
    checkOutput("rom write rdata", d1, 32'h0);
    romTxn(1'b0, 32'h0, BASE, e1, d1);
    checkOutput("rom reread error", 32'(e1), 32'd0);
    checkOutput("rom reread unchanged", d1, d0);
    checkOutput("rom err_count", 32'(rom_err_count), 32'd1);

    for (int i = 0; i < 16; i++) begin
      model_mem[i] = $urandom;
      v = '{1'b1, 4'hF, model_mem[i], BASE + 32'(4 * i), 1'b0, 32'h0};
      applyStimulus(v, $sformatf("init%0d", i));
    end

    // Back-pressure: ack low, three reads, third waits for the first pop.
    @(negedge g_clk);
    mem_ack = 1'b0; mem_req = 1'b1; mem_wen = 1'b0; mem_strb = 4'h0; mem_addr = BASE;
    checkOutput("bp gnt0", 32'(mem_gnt), 32'd1);
    checkOutput("bp recv0", 32'(mem_recv), 32'd0);
    @(negedge g_clk);
    mem_addr = BASE + 32'd4;
    checkOutput("bp gnt1", 32'(mem_gnt), 32'd1);
    checkOutput("bp rdata1", mem_rdata, model_mem[0]);
    @(negedge g_clk);
    mem_addr = BASE + 32'd8;
    checkOutput("bp full gnt", 32'(mem_gnt), 32'd0);
    checkOutput("bp full rdata", mem_rdata, model_mem[0]);
    @(negedge g_clk);
    checkOutput("bp hold gnt", 32'(mem_gnt), 32'd0);
    checkOutput("bp hold rdata", mem_rdata, model_mem[0]);
    mem_ack = 1'b1;
    @(negedge g_clk);
    checkOutput("bp pop1 gnt", 32'(mem_gnt), 32'd1);
    checkOutput("bp pop1 rdata", mem_rdata, model_mem[1]);
    @(negedge g_clk);
    mem_req = 1'b0;
    checkOutput("bp third recv", 32'(mem_recv), 32'd1);
    checkOutput("bp third rdata", mem_rdata, model_mem[2]);
    @(negedge g_clk);
    checkOutput("bp drained", 32'(mem_recv), 32'd0);

    // Reset with two queued responses and a write held through reset.
    mem_ack = 1'b0; mem_req = 1'b1; mem_wen = 1'b0; mem_addr = BASE + 32'd12;
    @(negedge g_clk);
    mem_addr = BASE + 32'd3;
    @(negedge g_clk);
    mem_req = 1'b0;
    if (err_model < 255) err_model++;
    checkOutput("rst queued recv", 32'(mem_recv), 32'd1);
    checkOutput("rst queued gnt", 32'(mem_gnt), 32'd0);
    checkOutput("rst queued err_count", 32'(err_count), 32'(err_model));
    g_reset = 1'b1;
    mem_req = 1'b1; mem_wen = 1'b1; mem_strb = 4'hF;
    mem_wdata = ~model_mem[5]; mem_addr = BASE + 32'd20;
    #1;
    checkOutput("rst async recv", 32'(mem_recv), 32'd0);
    checkOutput("rst async gnt", 32'(mem_gnt), 32'd0);
    checkOutput("rst async error", 32'(mem_error), 32'd0);
    checkOutput("rst async rdata", mem_rdata, 32'h0);
    checkOutput("rst async err_count", 32'(err_count), 32'd0);
    err_model = 0;
    @(posedge g_clk);
    @(negedge g_clk);
    g_reset = 1'b0; mem_req = 1'b0;
    #1;
    checkOutput("rst release gnt", 32'(mem_gnt), 32'd1);
    checkOutput("rst release recv", 32'(mem_recv), 32'd0);
    checkOutput("rst release err_count", 32'(err_count), 32'd0);
    v = '{1'b0, 4'h0, 32'h0, BASE + 32'd20, 1'b0, model_mem[5]};
    applyStimulus(v, "no write in reset");

    // Streaming: req and ack high every cycle.
    for (int i = 0; i < 8; i++) begin
      @(negedge g_clk);
      if (i > 0) begin
        checkOutput($sformatf("stream recv%0d", i), 32'(mem_recv), 32'd1);
        checkOutput($sformatf("stream rdata%0d", i), mem_rdata, model_mem[i-1]);
      end
      checkOutput($sformatf("stream gnt%0d", i), 32'(mem_gnt), 32'd1);
      mem_req = 1'b1; mem_wen = 1'b0; mem_ack = 1'b1; mem_addr = BASE + 32'(4 * i);
    end
    @(negedge g_clk);
    mem_req = 1'b0;
    checkOutput("stream last rdata", mem_rdata, model_mem[7]);
    @(negedge g_clk);
    checkOutput("stream drained", 32'(mem_recv), 32'd0);

    // Randomized traffic against an in-order queue model.
    exp_q.delete();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      int k;
      logic accept, popping;
      resp_t r;
      @(negedge g_clk);
      checkOutput("rand gnt", 32'(mem_gnt), 32'(exp_q.size() < 2));
      checkOutput("rand recv", 32'(mem_recv), 32'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
        checkOutput("rand error", 32'(mem_error), 32'(exp_q[0].err));
        checkOutput("rand rdata", mem_rdata, exp_q[0].data);
      end
      checkOutput("rand err_count", 32'(err_count), 32'(err_model));

      mem_req   = ($urandom_range(0, 3) != 0);
      mem_ack   = ($urandom_range(0, 2) != 0);
      mem_wen   = 1'($urandom_range(0, 1));
      mem_strb  = 4'($urandom);
      mem_wdata = $urandom;
      k = $urandom_range(0, 9);
      if (k < 7)       mem_addr = BASE + 32'(4 * $urandom_range(0, 15));
      else if (k == 7) mem_addr = BASE + 32'(4 * $urandom_range(0, 15) + $urandom_range(1, 3));
      else if (k == 8) mem_addr = BASE - 32'(4 * $urandom_range(1, 8));
      else             mem_addr = BASE + 32'h4000 + 32'(4 * $urandom_range(0, 8));

      accept  = mem_req && (exp_q.size() < 2);
      popping = (exp_q.size() > 0) && mem_ack;
      if (popping) void'(exp_q.pop_front());
      if (accept) begin
        r.err  = addr_is_error(mem_addr, mem_wen);
        r.data = 32'h0;
        if (!r.err) begin
          int idx;
          idx = int'((mem_addr - BASE) / 4);
          if (mem_wen) begin
            for (int b = 0; b < 4; b++)
              if (mem_strb[b]) model_mem[idx][8*b +: 8] = mem_wdata[8*b +: 8];
          end else begin
            r.data = model_mem[idx];
          end
        end else if (err_model < 255) begin
          err_model++;
        end
        exp_q.push_back(r);
      end
    end
    @(negedge g_clk);
    mem_req = 1'b0; mem_ack = 1'b1;
    repeat (3) @(negedge g_clk);
    checkOutput("final drained", 32'(mem_recv), 32'd0);
    checkOutput("final err_count", 32'(err_count), 32'(err_model));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
